imem_fetch_resp: RTL and testbench

Instruction-memory responder for the pipelined MIPS fetch stage. It accepts fetch requests carrying the current PC, reads the addressed word from an internal instruction store after a fixed multi-cycle latency, and returns it through a valid/ready handshake. While a fetch is outstanding it holds off further requests. `req_ready` is the fetch-side stall source that gates PC advancement. It also provides a word-load port for program loading and flags bad fetch addresses.

---
 rtl/imem_fetch_resp.sv | 131 +++++++++++++
 tb/tb_imem_fetch_resp.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_resp.sv
// Instruction-memory responder for the MIPS fetch stage: fixed-latency word read with valid/ready return.
// Optional address checking is enabled by defining IMEM_ADDR_CHECK_EN.
module imem_fetch_resp #(
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_addr,
    output logic [31:0] rsp_inst,
    output logic        rsp_err,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_addr_q, rsp_addr_d;
    logic [31:0] rsp_inst_q, rsp_inst_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] mem_q [DEPTH];
    logic        rd_bad, ld_bad;

    // Unchecked builds simply wrap the index modulo DEPTH.
    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

`ifdef IMEM_ADDR_CHECK_EN
    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < BASE_ADDR) || (((a - BASE_ADDR) >> 2) >= DEPTH);
    endfunction

    assign rd_bad = addr_bad(addr_q);
    assign ld_bad = addr_bad(ld_addr);
`else
    assign rd_bad = 1'b0;
    assign ld_bad = 1'b0;
`endif

    assign req_ready = (state_q == S_IDLE) && !flush;
    assign rsp_valid = rsp_valid_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_inst  = rsp_inst_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_inst_d  = rsp_inst_q;
        rsp_err_d   = rsp_err_q;
        if (flush) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            rsp_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_d  = req_addr;
                        cnt_d   = LAT_M1;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        // Store read sees pre-edge contents, so a colliding load lands after this read.
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_addr_d  = addr_q;
                        rsp_inst_d  = rd_bad ? 32'h0 : mem_q[word_idx(addr_q)];
                        rsp_err_d   = rd_bad;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_d     = S_IDLE;
                        rsp_valid_d = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= BASE_ADDR;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= BASE_ADDR;
            rsp_inst_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_inst_q  <= rsp_inst_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Program store is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (ld_en && !ld_bad) begin
            mem_q[word_idx(ld_addr)] <= ld_data;
        end
    end
endmodule

// File: tb/tb_imem_fetch_resp.sv
// Directed bench for imem_fetch_resp: LATENCY=2 main instance plus a LATENCY=1 instance.
module tb_imem_fetch_resp;
    logic        clk = 1'b0;
    logic        reset, flush, req_valid, rsp_ready, ld_en;
    logic [31:0] req_addr, ld_addr, ld_data;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_addr, rsp_inst;
    logic        req_valid1, rsp_ready1;
    logic [31:0] req_addr1;
    logic        req_ready1, rsp_valid1, rsp_err1;
    logic [31:0] rsp_addr1, rsp_inst1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imem_fetch_resp #(.LATENCY(2)) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
        .rsp_inst(rsp_inst), .rsp_err(rsp_err),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    imem_fetch_resp #(.LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid1), .req_addr(req_addr1), .req_ready(req_ready1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_addr(rsp_addr1),
        .rsp_inst(rsp_inst1), .rsp_err(rsp_err1),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_en = 1'b0;
    endtask

    task automatic do_fetch(input string tag, input logic [31:0] a,
                            input logic [31:0] exp_inst, input logic exp_err);
        req_valid = 1'b1; req_addr = a; rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        step();
        chk1({tag, "_valid"}, rsp_valid, 1'b1);
        chk32({tag, "_inst"}, rsp_inst, exp_inst);
        chk32({tag, "_addr"}, rsp_addr, a);
        chk1({tag, "_err"}, rsp_err, exp_err);
        rsp_ready = 1'b1;
        step();
        chk1({tag, "_done"}, rsp_valid, 1'b0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; flush = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        req_valid1 = 1'b0; req_addr1 = '0; rsp_ready1 = 1'b0;
        step(); step();

        chk1("rst_valid", rsp_valid, 1'b0);
        chk32("rst_addr", rsp_addr, 32'h0040_0000);
        chk32("rst_inst", rsp_inst, 32'h0);
        chk1("rst_err", rsp_err, 1'b0);
        chk1("rst_ready", req_ready, 1'b1);
        flush = 1'b1; #1;
        chk1("rst_ready_flush", req_ready, 1'b0);
        flush = 1'b0;
        reset = 1'b1;
        step();

        load(32'h0040_0000, 32'h2008_0005);
        load(32'h0040_0004, 32'h1111_1111);
        load(32'h0040_0008, 32'h2222_2222);
        load(32'h0040_0014, 32'h5555_5555);

        // First fetch, then hold the response under backpressure.
        req_valid = 1'b1; req_addr = 32'h0040_0000; #1;
        chk1("f0_ready", req_ready, 1'b1);
        step();
        req_valid = 1'b0;
        chk1("f0_e1_valid", rsp_valid, 1'b0);
        chk1("f0_e1_ready", req_ready, 1'b0);
        step();
        chk1("f0_e2_valid", rsp_valid, 1'b0);
        step();
        chk1("f0_e3_valid", rsp_valid, 1'b1);
        chk32("f0_inst", rsp_inst, 32'h2008_0005);
        chk32("f0_addr", rsp_addr, 32'h0040_0000);
        chk1("f0_err", rsp_err, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk1("bp_valid", rsp_valid, 1'b1);
            chk32("bp_inst", rsp_inst, 32'h2008_0005);
            chk32("bp_addr", rsp_addr, 32'h0040_0000);
            chk1("bp_ready", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        step();
        chk1("bp_release_valid", rsp_valid, 1'b0);
        chk1("bp_release_ready", req_ready, 1'b1);

        // Back-to-back fetches with rsp_ready high: one fetch per LATENCY+2 edges.
        req_valid = 1'b1; req_addr = 32'h0040_0004;
        step();
        chk1("tp_e0_valid", rsp_valid, 1'b0);
        step();
        chk1("tp_e1_valid", rsp_valid, 1'b0);
        step();
        chk1("tp_e2_valid", rsp_valid, 1'b1);
        chk32("tp_e2_inst", rsp_inst, 32'h1111_1111);
        step();
        chk1("tp_e3_valid", rsp_valid, 1'b0);
        chk1("tp_e3_ready", req_ready, 1'b1);
        step();
        chk1("tp_e4_ready", req_ready, 1'b0);
        req_valid = 1'b0;
        step();
        chk1("tp_e5_valid", rsp_valid, 1'b0);
        step();
        chk1("tp_e6_valid", rsp_valid, 1'b1);
        step();
        chk1("tp_e7_valid", rsp_valid, 1'b0);
        rsp_ready = 1'b0;

        // Flush while waiting: no response ever appears.
        req_valid = 1'b1; req_addr = 32'h0040_0000;
        step();
        req_valid = 1'b0; flush = 1'b1; #1;
        chk1("flw_ready", req_ready, 1'b0);
        step();
        flush = 1'b0; #1;
        chk1("flw_valid", rsp_valid, 1'b0);
        chk1("flw_idle", req_ready, 1'b1);
        step();
        chk1("flw_valid2", rsp_valid, 1'b0);
        step();
        chk1("flw_valid3", rsp_valid, 1'b0);

        // Flush while the response is presented.
        req_valid = 1'b1; req_addr = 32'h0040_0014;
        step();
        req_valid = 1'b0;
        step();
        step();
        chk1("flr_pre_valid", rsp_valid, 1'b1);
        flush = 1'b1; rsp_ready = 1'b1;
        step();
        flush = 1'b0; rsp_ready = 1'b0;
        chk1("flr_valid", rsp_valid, 1'b0);
        step();
        chk1("flr_valid2", rsp_valid, 1'b0);
        chk1("flr_ready", req_ready, 1'b1);
        do_fetch("after_flush", 32'h0040_0014, 32'h5555_5555, 1'b0);

`ifdef IMEM_ADDR_CHECK_EN
        do_fetch("misalign", 32'h0040_0002, 32'h0, 1'b1);
        do_fetch("over_range", 32'h0040_0400, 32'h0, 1'b1);
        do_fetch("under_range", 32'h003F_FFFC, 32'h0, 1'b1);
`else
        do_fetch("wrap", 32'h0040_0400, 32'h2008_0005, 1'b0);
        do_fetch("lowbits", 32'h0040_0006, 32'h1111_1111, 1'b0);
`endif

        // Load into the fetched word on the WAIT->RESP edge.
        req_valid = 1'b1; req_addr = 32'h0040_0008;
        step();
        req_valid = 1'b0;
        step();
        ld_en = 1'b1; ld_addr = 32'h0040_0008; ld_data = 32'hDEAD_BEEF;
        step();
        ld_en = 1'b0;
        chk1("coll_valid", rsp_valid, 1'b1);
        chk32("coll_inst", rsp_inst, 32'h2222_2222);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        do_fetch("coll_refetch", 32'h0040_0008, 32'hDEAD_BEEF, 1'b0);

        // Asynchronous reset in the middle of a fetch.
        req_valid = 1'b1; req_addr = 32'h0040_0004;
        step();
        req_valid = 1'b0;
        reset = 1'b0; #1;
        chk1("mrst_valid", rsp_valid, 1'b0);
        chk1("mrst_ready", req_ready, 1'b1);
        step();
        reset = 1'b1;
        step();
        chk1("mrst_rel_valid", rsp_valid, 1'b0);
        step();
        chk1("mrst_rel_valid2", rsp_valid, 1'b0);
        chk1("mrst_rel_ready", req_ready, 1'b1);
        do_fetch("post_rst", 32'h0040_0004, 32'h1111_1111, 1'b0);

        // LATENCY=1 instance: response one edge after accept.
        req_valid1 = 1'b1; req_addr1 = 32'h0040_0004; #1;
        chk1("l1_ready", req_ready1, 1'b1);
        step();
        req_valid1 = 1'b0;
        chk1("l1_e0_valid", rsp_valid1, 1'b0);
        step();
        chk1("l1_e1_valid", rsp_valid1, 1'b1);
        chk32("l1_inst", rsp_inst1, 32'h1111_1111);
        chk32("l1_addr", rsp_addr1, 32'h0040_0004);
        chk1("l1_err", rsp_err1, 1'b0);
        rsp_ready1 = 1'b1;
        step();
        chk1("l1_done_valid", rsp_valid1, 1'b0);
        chk1("l1_done_ready", req_ready1, 1'b1);
        rsp_ready1 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
